// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
   typedef enum logic {OWN_IF, OWN_DM} owner_t;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Two-way requester selector: fixed DM-over-IF, or round-robin when ARB_RR_EN is defined.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic   if_req,
   input  logic   dm_req,
   input  owner_t rr_last,
   output logic   vld,
   output owner_t pick
);

   assign vld = if_req | dm_req;

`ifdef ARB_RR_EN
   // On contention the requester not served last wins.
   always_comb begin
      pick = OWN_DM;
      if (if_req && dm_req) pick = (rr_last == OWN_DM) ? OWN_IF : OWN_DM;
      else if (if_req)      pick = OWN_IF;
   end
`else
   logic unused_rr;
   assign unused_rr = (rr_last == OWN_IF);

   always_comb begin
      pick = OWN_DM;
      if (!dm_req && if_req) pick = OWN_IF;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding bus port shared by fetch and load/store, with flush drop and watchdog.
// Optional macro ARB_RR_EN selects round-robin arbitration instead of fixed DM priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_done,
   output logic                if_stall,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_wstrb,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_done,
   output logic                dm_stall,
   input  logic                flush,
   output logic                bus_req,
   output logic                bus_we,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_wstrb,
   input  logic                bus_gnt,
   input  logic                bus_rvalid,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic                bus_timeout
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   state_t        state;
   owner_t        owner, rr_last, pick;
   logic          pick_vld, kill;
   logic [CW-1:0] cnt;
   logic          busy, rsp, rsp_drop, abort, killed_now, done, to_idle;

   arb_pick u_pick (
      .if_req  (if_req),
      .dm_req  (dm_req),
      .rr_last (rr_last),
      .vld     (pick_vld),
      .pick    (pick)
   );

   assign busy       = (state != IDLE);
   assign rsp        = (state == WAIT) && bus_rvalid;
   assign rsp_drop   = (state == DROP) && bus_rvalid;
   // A real response always beats the watchdog in the same cycle.
   assign abort      = busy && (cnt == CW'(TIMEOUT_CYC - 1)) && !rsp && !rsp_drop;
   assign killed_now = (owner == OWN_IF) && (kill || flush);
   assign done       = (rsp || (abort && state != DROP)) && !killed_now;
   assign to_idle    = rsp || rsp_drop || abort;

   assign if_done  = done && (owner == OWN_IF);
   assign dm_done  = done && (owner == OWN_DM);
   assign if_rdata = (if_done && rsp) ? bus_rdata : '0;
   assign dm_rdata = (dm_done && rsp) ? bus_rdata : '0;
   assign if_stall = if_req && !if_done;
   assign dm_stall = dm_req && !dm_done;

`ifdef ARB_RR_EN
   owner_t rr_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rr_q <= OWN_DM;
      else if (to_idle) rr_q <= owner;
   end
   assign rr_last = rr_q;
`else
   assign rr_last = OWN_DM;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= OWN_DM;
         kill        <= 1'b0;
         cnt         <= '0;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
         bus_wstrb   <= '0;
         bus_timeout <= 1'b0;
      end else begin
         cnt <= (!busy || to_idle) ? '0 : cnt + CW'(1);
         if (abort) begin
            bus_timeout <= 1'b1;
            bus_req     <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               kill <= 1'b0;
               if (pick_vld) begin
                  owner   <= pick;
                  bus_req <= 1'b1;
                  state   <= REQ;
                  if (pick == OWN_DM) begin
                     bus_we    <= dm_we;
                     bus_addr  <= dm_addr;
                     bus_wdata <= dm_wdata;
                     bus_wstrb <= dm_wstrb;
                  end else begin
                     bus_we    <= 1'b0;
                     bus_addr  <= if_addr;
                     bus_wdata <= '0;
                     bus_wstrb <= '0;
                  end
               end
            end
            REQ: begin
               // A killed fetch keeps requesting; its answer is swallowed in DROP.
               if (abort) state <= IDLE;
               else begin
                  if (flush && owner == OWN_IF) kill <= 1'b1;
                  if (bus_gnt) begin
                     bus_req <= 1'b0;
                     state   <= killed_now ? DROP : WAIT;
                  end
               end
            end
            WAIT: begin
               if (abort || rsp)                    state <= IDLE;
               else if (flush && owner == OWN_IF)   state <= DROP;
            end
            DROP: begin
               if (abort || rsp_drop) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard and negedge monitor.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 0, dm_req = 0, dm_we = 0, flush = 0;
   logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
   logic [3:0]  dm_wstrb = 0;
   logic        bus_gnt = 0, bus_rvalid = 0;
   logic [31:0] bus_rdata = 0;
   logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
   logic        if_done, if_stall, dm_done, dm_stall;
   logic        bus_req, bus_we, bus_timeout;
   logic [3:0]  bus_wstrb;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        is_dm;
      logic [31:0] data;
      logic        chk_data;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
      .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
      .flush(flush),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_timeout(bus_timeout)
   );

   // Monitor: every done pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (if_done || dm_done) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done if_done=%0b dm_done=%0b", if_done, dm_done);
         end else begin
            exp_t e;
            logic [31:0] got;
            e = sb.pop_front();
            got = e.is_dm ? dm_rdata : if_rdata;
            if ((if_done && dm_done) || (dm_done != e.is_dm) || (e.chk_data && got !== e.data)) begin
               errors++;
               $display("FAIL scoreboard got dm_done=%0b if_done=%0b rdata=0x%0h required is_dm=%0b rdata=0x%0h",
                        dm_done, if_done, got, e.is_dm, e.data);
            end
         end
      end
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", n, act, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   function automatic exp_t mk(input logic is_dm, input logic [31:0] d, input logic c);
      exp_t e;
      e.is_dm = is_dm; e.data = d; e.chk_data = c;
      return e;
   endfunction

   // Called right after the latch cycle: REQ with immediate grant, WAIT with response, then release.
   task automatic txn_fast(input logic [31:0] addr, input logic is_dm, input logic [31:0] d);
      nxt; bus_gnt = 1;
      mid; chk("txn_addr", bus_addr, addr); chk("txn_req", 32'(bus_req), 1);
      nxt; bus_gnt = 0; bus_rvalid = 1; bus_rdata = d; sb.push_back(mk(is_dm, d, 1'b1));
      mid;
      nxt; bus_rvalid = 0;
      if (is_dm) dm_req = 0; else if_req = 0;
   endtask

   initial begin
      // Reset state
      mid;
      chk("rst_bus_req", 32'(bus_req), 0);
      chk("rst_timeout", 32'(bus_timeout), 0);
      chk("rst_done", {30'd0, if_done, dm_done}, 0);
      nxt; rst = 0;

      // Fetch only, grant in cycle 2, data in cycle 4
      nxt; if_req = 1; if_addr = 32'h100;
      mid; chk("f_stall_c0", 32'(if_stall), 1); chk("f_req_c0", 32'(bus_req), 0);
      nxt; mid; chk("f_req_c1", 32'(bus_req), 1); chk("f_addr_c1", bus_addr, 32'h100); chk("f_we_c1", 32'(bus_we), 0);
      nxt; bus_gnt = 1; mid; chk("f_req_c2", 32'(bus_req), 1);
      nxt; bus_gnt = 0; mid; chk("f_req_c3", 32'(bus_req), 0); chk("f_stall_c3", 32'(if_stall), 1);
      nxt; bus_rvalid = 1; bus_rdata = 32'hDEADBEEF; sb.push_back(mk(1'b0, 32'hDEADBEEF, 1'b1));
      mid; chk("f_done_c4", 32'(if_done), 1); chk("f_stall_c4", 32'(if_stall), 0);
      nxt; bus_rvalid = 0; if_req = 0; mid; chk("f_req_c5", 32'(bus_req), 0);

      // Contention after IF was served last: DM first in either mode
      nxt; if_req = 1; if_addr = 32'h108; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
      txn_fast(32'h200, 1'b1, 32'h11111111);
      txn_fast(32'h108, 1'b0, 32'h22222222);

      // Flush in WAIT of fetch 0x104; response two cycles later is dropped
      nxt; if_req = 1; if_addr = 32'h104;
      nxt; bus_gnt = 1; mid; chk("fl_addr", bus_addr, 32'h104);
      nxt; bus_gnt = 0; flush = 1; mid; chk("fl_done_w", 32'(if_done), 0);
      nxt; flush = 0; if_addr = 32'h300; mid; chk("fl_done_d", 32'(if_done), 0); chk("fl_stall", 32'(if_stall), 1);
      nxt; bus_rvalid = 1; bus_rdata = 32'hBAD0BAD0; mid; chk("fl_drop_rsp", 32'(if_done), 0);
      nxt; bus_rvalid = 0; mid; chk("fl_idle_req", 32'(bus_req), 0);
      txn_fast(32'h300, 1'b0, 32'h33333333);

      // Flush coincident with the fetch response
      nxt; if_req = 1; if_addr = 32'h500;
      nxt; bus_gnt = 1; mid; chk("fr_addr", bus_addr, 32'h500);
      nxt; bus_gnt = 0; bus_rvalid = 1; flush = 1; bus_rdata = 32'h55555555;
      mid; chk("fr_done", 32'(if_done), 0);
      nxt; bus_rvalid = 0; flush = 0; if_req = 0; mid; chk("fr_idle", 32'(bus_req), 0);
      nxt; mid; chk("fr_no_reissue", 32'(bus_req), 0);

      // Flush during a DM store does not affect it
      nxt; dm_req = 1; dm_we = 1; dm_addr = 32'h400; dm_wdata = 32'hCAFEF00D; dm_wstrb = 4'b0011;
      nxt; bus_gnt = 1; flush = 1;
      mid; chk("st_we", 32'(bus_we), 1); chk("st_wstrb", 32'(bus_wstrb), 32'h3);
      chk("st_wdata", bus_wdata, 32'hCAFEF00D); chk("st_addr", bus_addr, 32'h400);
      nxt; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h0; sb.push_back(mk(1'b1, 32'h0, 1'b0));
      mid; chk("st_done", 32'(dm_done), 1);
      nxt; bus_rvalid = 0; flush = 0; dm_req = 0; dm_we = 0; dm_wstrb = 4'b0;

      // Contention after DM was served last
      nxt; if_req = 1; if_addr = 32'h600; dm_req = 1; dm_addr = 32'h700;
`ifdef ARB_RR_EN
      txn_fast(32'h600, 1'b0, 32'h66666666);
      txn_fast(32'h700, 1'b1, 32'h77777777);
`else
      txn_fast(32'h700, 1'b1, 32'h77777777);
      txn_fast(32'h600, 1'b0, 32'h66666666);
`endif

      // Watchdog: no grant, abort in the 4th REQ cycle with rdata 0
      nxt; dm_req = 1; dm_addr = 32'h800; bus_rdata = 32'hFFFFFFFF; sb.push_back(mk(1'b1, 32'h0, 1'b1));
      for (int i = 0; i < 3; i++) begin
         nxt; mid; chk("to_req", 32'(bus_req), 1); chk("to_nodone", 32'(dm_done), 0);
      end
      nxt; mid; chk("to_done", 32'(dm_done), 1); chk("to_flag_pre", 32'(bus_timeout), 0);
      nxt; dm_req = 0; mid; chk("to_flag", 32'(bus_timeout), 1); chk("to_req_clr", 32'(bus_req), 0);
      nxt; mid; chk("to_sticky", 32'(bus_timeout), 1);

      // Asynchronous reset while in WAIT, then a late response
      nxt; if_req = 1; if_addr = 32'h900;
      nxt; bus_gnt = 1;
      nxt; bus_gnt = 0;
      #2 rst = 1;
      #1 chk("ar_addr", bus_addr, 0); chk("ar_timeout", 32'(bus_timeout), 0);
      chk("ar_req", 32'(bus_req), 0); chk("ar_done", 32'(if_done), 0);
      if_req = 0;
      nxt;
      nxt; rst = 0; bus_rvalid = 1; bus_rdata = 32'h12345678;
      mid; chk("ar_late_if", 32'(if_done), 0); chk("ar_late_dm", 32'(dm_done), 0);
      nxt; bus_rvalid = 0; mid; chk("ar_idle", 32'(bus_req), 0);

      chk("sb_empty", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
